// File: rtl/serial_pkg.sv
// Shared constants and FSM state type for the serial transmitter/receiver pair.
// The deserializer reuses WORD_W from here.
package serial_pkg;

   localparam int WORD_W = 8;
   localparam int CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } serial_state_e;

endpackage

// File: rtl/serial_hold_reg.sv
// One-byte holding buffer for the serializer: lets the next byte be accepted
// while the current frame is still shifting out.
module serial_hold_reg
   import serial_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              release_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [WORD_W-1:0] data_q, data_d;

   // Load only happens while empty, so it never collides with a release.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (release_i) begin
         valid_d = 1'b0;
      end
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: 8-bit bytes in over write/status, MSB-first
// bits out over write/ack. Optional even-parity bit: define SERIALIZADOR_PARITY_EN.
module serializador
   import serial_pkg::*;
(
   input  logic              clk_100KHz,
   input  logic              reset,
   input  logic [WORD_W-1:0] data_in,
   input  logic              write_in,
   output logic              status_out,
   output logic              data_out,
   output logic              write_out,
   input  logic              ack_in,
   output logic              busy_out,
   output logic              done_out
);

   serial_state_e     state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dataOut_q, dataOut_d;
   logic              writeOut_q, writeOut_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef SERIALIZADOR_PARITY_EN
   logic              parity_q, parity_d;
`endif

   logic              holdValid;
   logic [WORD_W-1:0] holdData;
   logic              holdLoad;
   logic              holdRelease;

   logic              xfer;
   logic              accept;
   logic              lastBit;
   logic              frameEnd;
   logic              loadShift;
   logic [WORD_W-1:0] loadByte;

   serial_hold_reg u_hold (
      .clk_i     (clk_100KHz),
      .rst_ni    (reset),
      .load_i    (holdLoad),
      .data_i    (data_in),
      .release_i (holdRelease),
      .valid_o   (holdValid),
      .data_o    (holdData)
   );

   assign xfer    = writeOut_q & ack_in;
   assign accept  = write_in & ~holdValid;
   assign lastBit = (state_q == SHIFT) && (cnt_q == '0) && xfer;

`ifdef SERIALIZADOR_PARITY_EN
   assign frameEnd = (state_q == PARITY) && xfer;
`else
   assign frameEnd = lastBit;
`endif

   // Frame end refills from the holding register first, then from a fresh write.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      dataOut_d   = dataOut_q;
      writeOut_d  = writeOut_q;
      done_d      = frameEnd;
      holdLoad    = 1'b0;
      holdRelease = 1'b0;
      loadShift   = 1'b0;
      loadByte    = data_in;
`ifdef SERIALIZADOR_PARITY_EN
      parity_d    = parity_q;
`endif

      if (state_q == IDLE) begin
         loadShift = accept;
      end else if (frameEnd) begin
         if (holdValid) begin
            loadShift   = 1'b1;
            loadByte    = holdData;
            holdRelease = 1'b1;
         end else if (accept) begin
            loadShift = 1'b1;
         end else begin
            state_d    = IDLE;
            writeOut_d = 1'b0;
            dataOut_d  = 1'b0;
            cnt_d      = CNT_W'(WORD_W - 1);
         end
      end else begin
         holdLoad = accept;
         if (xfer) begin
`ifdef SERIALIZADOR_PARITY_EN
            if (lastBit) begin
               state_d   = PARITY;
               dataOut_d = parity_q;
            end else
`endif
            if (cnt_q != '0) begin
               cnt_d     = cnt_q - CNT_W'(1);
               dataOut_d = shift_q[cnt_q - CNT_W'(1)];
            end
         end
      end

      if (loadShift) begin
         state_d    = SHIFT;
         shift_d    = loadByte;
         cnt_d      = CNT_W'(WORD_W - 1);
         dataOut_d  = loadByte[WORD_W-1];
         writeOut_d = 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
         parity_d   = ^loadByte;
`endif
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_100KHz or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= CNT_W'(WORD_W - 1);
         dataOut_q  <= 1'b0;
         writeOut_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         dataOut_q  <= dataOut_d;
         writeOut_q <= writeOut_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef SERIALIZADOR_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign status_out = ~holdValid;
   assign data_out   = dataOut_q;
   assign write_out  = writeOut_q;
   assign busy_out   = busy_q;
   assign done_out   = done_q;

endmodule

// File: tb/tb_serializador.sv
// Directed, table-driven bench for serializador. Expected vector bits are
// {data_out, write_out, status_out, busy_out, done_out} after each clock edge.
module tb_serializador;

   typedef struct {
      logic       wr;
      logic [7:0] din;
      logic       ack;
      logic       expData;
      logic       expWrite;
      logic       expStatus;
      logic       expBusy;
      logic       expDone;
   } vec_t;

   logic       clk_100KHz = 1'b0;
   logic       reset      = 1'b0;
   logic [7:0] data_in    = 8'h00;
   logic       write_in   = 1'b0;
   logic       ack_in     = 1'b0;
   logic       status_out;
   logic       data_out;
   logic       write_out;
   logic       busy_out;
   logic       done_out;

   int   assertCount = 0;
   int   failCount   = 0;
   vec_t tbl[$];

   always #5 clk_100KHz = ~clk_100KHz;

   serializador dut (
      .clk_100KHz (clk_100KHz),
      .reset      (reset),
      .data_in    (data_in),
      .write_in   (write_in),
      .status_out (status_out),
      .data_out   (data_out),
      .write_out  (write_out),
      .ack_in     (ack_in),
      .busy_out   (busy_out),
      .done_out   (done_out)
   );

   task automatic checkOutput(input string name, input logic act, input logic req);
      assertCount++;
      if (act !== req) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic addVec(input logic wr, input logic [7:0] din, input logic ack,
                         input logic [4:0] e);
      vec_t v;
      v.wr        = wr;
      v.din       = din;
      v.ack       = ack;
      v.expData   = e[4];
      v.expWrite  = e[3];
      v.expStatus = e[2];
      v.expBusy   = e[1];
      v.expDone   = e[0];
      tbl.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      write_in = v.wr;
      data_in  = v.din;
      ack_in   = v.ack;
      @(posedge clk_100KHz);
      #1;
      checkOutput({tag, ".data_out"},   data_out,   v.expData);
      checkOutput({tag, ".write_out"},  write_out,  v.expWrite);
      checkOutput({tag, ".status_out"}, status_out, v.expStatus);
      checkOutput({tag, ".busy_out"},   busy_out,   v.expBusy);
      checkOutput({tag, ".done_out"},   done_out,   v.expDone);
   endtask

   task automatic runTable(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i], $sformatf("%s[%0d]", name, i));
      end
      tbl.delete();
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".data_out"},   data_out,   1'b0);
      checkOutput({tag, ".write_out"},  write_out,  1'b0);
      checkOutput({tag, ".status_out"}, status_out, 1'b1);
      checkOutput({tag, ".busy_out"},   busy_out,   1'b0);
      checkOutput({tag, ".done_out"},   done_out,   1'b0);
   endtask

   initial begin
      logic ackSeq [14];
      ackSeq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      #12;
      checkIdle("reset");
      reset = 1'b1;

`ifndef SERIALIZADOR_PARITY_EN
      // A5 = 1010_0101 with ack held high
      addVec(1, 8'hA5, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b00101);
      addVec(0, 8'h00, 1, 5'b00100);
      runTable("a5");

      // 3C, C3 back-to-back; write_in held with 5A while holding register full
      addVec(1, 8'h3C, 1, 5'b01110);
      addVec(1, 8'hC3, 1, 5'b01010);
      addVec(1, 8'h5A, 1, 5'b11010);
      addVec(1, 8'h5A, 1, 5'b11010);
      addVec(1, 8'h5A, 1, 5'b11010);
      addVec(1, 8'h5A, 1, 5'b11010);
      addVec(1, 8'h5A, 1, 5'b01010);
      addVec(1, 8'h5A, 1, 5'b01010);
      addVec(1, 8'h5A, 1, 5'b11111);
      addVec(1, 8'h5A, 1, 5'b11010);
      addVec(0, 8'h00, 1, 5'b01010);
      addVec(0, 8'h00, 1, 5'b01010);
      addVec(0, 8'h00, 1, 5'b01010);
      addVec(0, 8'h00, 1, 5'b01010);
      addVec(0, 8'h00, 1, 5'b11010);
      addVec(0, 8'h00, 1, 5'b11010);
      addVec(0, 8'h00, 1, 5'b01111);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b00101);
      addVec(0, 8'h00, 1, 5'b00100);
      runTable("b2b");

      // FF with stalls: exactly 8 acknowledged transfers before done
      addVec(1, 8'hFF, 1, 5'b11110);
      for (int i = 0; i < 13; i++) begin
         addVec(0, 8'(i * 37), ackSeq[i], 5'b11110);
      end
      addVec(0, 8'h00, ackSeq[13], 5'b00101);
      addVec(0, 8'h00, 1'b0, 5'b00100);
      runTable("stall");

      // 96 = 1001_0110 with 55 held, reset asserted once bit3 is on the line
      addVec(1, 8'h96, 1, 5'b11110);
      addVec(1, 8'h55, 1, 5'b01010);
      addVec(0, 8'h00, 1, 5'b01010);
      addVec(0, 8'h00, 1, 5'b11010);
      addVec(0, 8'h00, 1, 5'b01010);
      runTable("preReset");
      reset = 1'b0;
      #1;
      checkIdle("midReset");
      #2;
      reset = 1'b1;

      // 81 = 1000_0001 after reset: a clean frame and no leftover held byte
      addVec(1, 8'h81, 1, 5'b11110);
      for (int i = 0; i < 6; i++) begin
         addVec(0, 8'h00, 1, 5'b01110);
      end
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b00101);
      addVec(0, 8'h00, 1, 5'b00100);
      runTable("postReset");
`else
      // 07 = 0000_0111, even parity bit 1
      addVec(1, 8'h07, 1, 5'b01110);
      for (int i = 0; i < 4; i++) begin
         addVec(0, 8'h00, 1, 5'b01110);
      end
      for (int i = 0; i < 3; i++) begin
         addVec(0, 8'h00, 1, 5'b11110);
      end
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b00101);
      addVec(0, 8'h00, 1, 5'b00100);
      runTable("par07");

      // 03 = 0000_0011, even parity bit 0
      addVec(1, 8'h03, 1, 5'b01110);
      for (int i = 0; i < 5; i++) begin
         addVec(0, 8'h00, 1, 5'b01110);
      end
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b11110);
      addVec(0, 8'h00, 1, 5'b01110);
      addVec(0, 8'h00, 1, 5'b00101);
      addVec(0, 8'h00, 1, 5'b00100);
      runTable("par03");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
